// File: rtl/conv_sequencer.sv
// Sequencer for the multi-channel binary convolution datapath.
// Streams kernels and image rows from SRAM and writes output rows.
module conv_sequencer #(
    parameter int IMG_DIM  = 16,
    parameter int KER_DIM  = 3,
    parameter int NUM_CH   = 1,
    parameter int ADDR_W   = 12,
    parameter int RD_LAT   = 1,
    parameter int IN_BASE  = 0,
    parameter int KER_BASE = 64,
    parameter int OUT_BASE = 128,
    localparam int KR_W = $clog2(KER_DIM),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    output logic              ker_capture,
    output logic [KR_W-1:0]   ker_row,
    output logic              row_shift,
    output logic [CH_W-1:0]   ch_idx,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_wr_addr
);

    localparam int OUT_ROWS = IMG_DIM - KER_DIM + 1;
    localparam int PW = $clog2(RD_LAT + 2);
    localparam int RW = $clog2(IMG_DIM + 1);

    // phase within one read step: read at 0, capture at RD_LAT,
    // output write at RD_LAT+1 (RUN only)
    localparam logic [PW-1:0] PH_CAP = PW'(RD_LAT);
    localparam logic [PW-1:0] PH_WR  = PW'(RD_LAT + 1);

    localparam logic [RW-1:0] K_LAST = RW'(KER_DIM - 1);
    localparam logic [RW-1:0] P_LAST = RW'(KER_DIM - 2);
    localparam logic [RW-1:0] R_LAST = RW'(OUT_ROWS - 1);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KER,
        S_PRIME,
        S_RUN,
        S_NEXT_CH,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]   ph_q, ph_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CH_W-1:0] ch_q, ch_d;

    logic              busy_d;
    logic              done_d;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              ker_cap_d;
    logic [KR_W-1:0]   ker_row_d;
    logic              shift_d;
    logic              we_d;
    logic [ADDR_W-1:0] wr_addr_d;

    // State, phase, row and channel register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ph_q    <= '0;
            row_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            row_q   <= row_d;
            ch_q    <= ch_d;
        end
    end

    // Next-state logic: walks read steps through each phase of a channel
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        row_d   = row_q;
        ch_d    = ch_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_LOAD_KER;
                    ph_d    = '0;
                    row_d   = '0;
                    ch_d    = '0;
                end
            end
            S_LOAD_KER: begin
                if (ph_q == PH_CAP) begin
                    ph_d = '0;
                    if (row_q == K_LAST) begin
                        row_d   = '0;
                        state_d = S_PRIME;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_PRIME: begin
                if (ph_q == PH_CAP) begin
                    ph_d = '0;
                    if (row_q == P_LAST) begin
                        row_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_RUN: begin
                if (ph_q == PH_WR) begin
                    ph_d = '0;
                    if (row_q == R_LAST) begin
                        row_d   = '0;
                        state_d = S_NEXT_CH;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            S_NEXT_CH: begin
                ph_d  = '0;
                row_d = '0;
                if (ch_q == CH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_LOAD_KER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ch_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
                ph_d    = '0;
                row_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    // Output decode from the next state so every strobe leaves a flop
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = '0;
        ker_cap_d = 1'b0;
        ker_row_d = '0;
        shift_d   = 1'b0;
        we_d      = 1'b0;
        wr_addr_d = '0;
        unique case (state_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_LOAD_KER: begin
                busy_d    = 1'b1;
                rd_en_d   = (ph_d == '0);
                ker_cap_d = (ph_d == PH_CAP);
                ker_row_d = KR_W'(row_d);
                if (ph_d == '0) begin
                    rd_addr_d = ADDR_W'(KER_BASE
                              + 32'(ch_d) * KER_DIM
                              + 32'(row_d));
                end
            end
            S_PRIME: begin
                busy_d  = 1'b1;
                rd_en_d = (ph_d == '0);
                shift_d = (ph_d == PH_CAP);
                if (ph_d == '0) begin
                    rd_addr_d = ADDR_W'(IN_BASE + 32'(row_d));
                end
            end
            S_RUN: begin
                busy_d  = 1'b1;
                rd_en_d = (ph_d == '0);
                shift_d = (ph_d == PH_CAP);
                we_d    = (ph_d == PH_WR);
                if (ph_d == '0) begin
                    rd_addr_d = ADDR_W'(IN_BASE
                              + 32'(row_d)
                              + KER_DIM - 1);
                end
                if (ph_d == PH_WR) begin
                    wr_addr_d = ADDR_W'(OUT_BASE
                              + 32'(ch_d) * OUT_ROWS
                              + 32'(row_d));
                end
            end
            S_NEXT_CH: begin
                busy_d = 1'b1;
            end
            S_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered outputs, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            sram_rd_en   <= 1'b0;
            sram_rd_addr <= '0;
            ker_capture  <= 1'b0;
            ker_row      <= '0;
            row_shift    <= 1'b0;
            ch_idx       <= '0;
            sram_we      <= 1'b0;
            sram_wr_addr <= '0;
        end else begin
            busy         <= busy_d;
            done         <= done_d;
            sram_rd_en   <= rd_en_d;
            sram_rd_addr <= rd_addr_d;
            ker_capture  <= ker_cap_d;
            ker_row      <= ker_row_d;
            row_shift    <= shift_d;
            ch_idx       <= ch_d;
            sram_we      <= we_d;
            sram_wr_addr <= wr_addr_d;
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: three configurations checked against
// a timing scoreboard built from the documented per-row costs.
module tb_conv_sequencer;

    typedef struct {
        int cyc;
        int val;
        int ch;
    } ev_t;

    // per instance: channels, kernel rows, read latency, rows, out base
    localparam int P_N   [3] = '{1, 3, 1};
    localparam int P_K   [3] = '{3, 3, 3};
    localparam int P_L   [3] = '{1, 1, 3};
    localparam int P_IMG [3] = '{16, 8, 16};
    localparam int P_OB  [3] = '{128, 128, 4090};

    logic clk;
    logic reset;
    logic go_a, go_b, go_c;
    logic armed;

    logic        a_bz, a_dn, a_rd, a_cap, a_sh, a_we;
    logic [11:0] a_ra, a_wa;
    logic [1:0]  a_kr;
    logic        a_ch;

    logic        b_bz, b_dn, b_rd, b_cap, b_sh, b_we;
    logic [11:0] b_ra, b_wa;
    logic [1:0]  b_kr;
    logic [1:0]  b_ch;

    logic        c_bz, c_dn, c_rd, c_cap, c_sh, c_we;
    logic [11:0] c_ra, c_wa;
    logic [1:0]  c_kr;
    logic        c_ch;

    int   checks;
    int   failures;
    int   cyc;
    ev_t  q [15][$];
    int   run_start [3];
    int   run_end [3];
    int   last_rd [3];
    int   last_sh [3];
    int   we_cnt [3];
    int   done_cnt [3];

    conv_sequencer u_a (
        .clk(clk), .reset(reset), .go(go_a),
        .busy(a_bz), .done(a_dn),
        .sram_rd_en(a_rd), .sram_rd_addr(a_ra),
        .ker_capture(a_cap), .ker_row(a_kr),
        .row_shift(a_sh), .ch_idx(a_ch),
        .sram_we(a_we), .sram_wr_addr(a_wa)
    );

    conv_sequencer #(.IMG_DIM(8), .NUM_CH(3)) u_b (
        .clk(clk), .reset(reset), .go(go_b),
        .busy(b_bz), .done(b_dn),
        .sram_rd_en(b_rd), .sram_rd_addr(b_ra),
        .ker_capture(b_cap), .ker_row(b_kr),
        .row_shift(b_sh), .ch_idx(b_ch),
        .sram_we(b_we), .sram_wr_addr(b_wa)
    );

    conv_sequencer #(.RD_LAT(3), .OUT_BASE(4090)) u_c (
        .clk(clk), .reset(reset), .go(go_c),
        .busy(c_bz), .done(c_dn),
        .sram_rd_en(c_rd), .sram_rd_addr(c_ra),
        .ker_capture(c_cap), .ker_row(c_kr),
        .row_shift(c_sh), .ch_idx(c_ch),
        .sram_we(c_we), .sram_wr_addr(c_wa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string tag(string s, int i);
        return $sformatf("%s_%0d", s, i);
    endfunction

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", nm, obs, exp);
        end
    endtask

    task automatic push(int idx, int t, int v, int c);
        ev_t e;
        e.cyc = t;
        e.val = v;
        e.ch  = c;
        q[idx].push_back(e);
    endtask

    // expected event schedule of one run; goc is the cycle go was high
    task automatic plan(int i, int goc);
        int k, l, orows, cc, base, t0, t1, t;
        k     = P_K[i];
        l     = P_L[i];
        orows = P_IMG[i] - k + 1;
        cc    = k * (l + 1) + (k - 1) * (l + 1) + orows * (l + 2) + 1;
        for (int c = 0; c < P_N[i]; c++) begin
            base = goc + 1 + c * cc;
            for (int kk = 0; kk < k; kk++) begin
                t = base + kk * (l + 1);
                push(i * 5 + 0, t, (64 + c * k + kk) & 4095, 0);
                push(i * 5 + 1, t + l, kk, c);
            end
            t0 = base + k * (l + 1);
            for (int p = 0; p < k - 1; p++) begin
                t = t0 + p * (l + 1);
                push(i * 5 + 0, t, p, 0);
                push(i * 5 + 2, t + l, 0, 0);
            end
            t1 = t0 + (k - 1) * (l + 1);
            for (int r = 0; r < orows; r++) begin
                t = t1 + r * (l + 2);
                push(i * 5 + 0, t, r + k - 1, 0);
                push(i * 5 + 2, t + l, 0, 0);
                push(i * 5 + 3, t + l + 1,
                     (P_OB[i] + c * orows + r) & 4095, 0);
            end
        end
        push(i * 5 + 4, goc + 1 + P_N[i] * cc, 0, 0);
        run_start[i] = goc + 1;
        run_end[i]   = goc + 1 + P_N[i] * cc;
    endtask

    task automatic take(int i, int kind, string nm,
                        logic [31:0] val, logic [31:0] ch);
        ev_t e;
        chk(tag({nm, "_expected"}, i), 32'(q[i * 5 + kind].size() != 0), 1);
        if (q[i * 5 + kind].size() != 0) begin
            e = q[i * 5 + kind].pop_front();
            chk(tag({nm, "_cycle"}, i), 32'(cyc), 32'(e.cyc));
            if (kind == 0 || kind == 1 || kind == 3)
                chk(tag({nm, "_val"}, i), val, 32'(e.val));
            if (kind == 1)
                chk(tag({nm, "_ch"}, i), ch, 32'(e.ch));
        end
    endtask

    task automatic mon(int i, logic bz, logic dn, logic rd,
                       logic [31:0] ra, logic cap, logic [31:0] kr,
                       logic sh, logic [31:0] ch, logic we,
                       logic [31:0] wa);
        logic exp_bz;
        exp_bz = (cyc >= run_start[i]) && (cyc <= run_end[i]);
        chk(tag("busy", i), 32'(bz), 32'(exp_bz));
        chk(tag("cap_shift_excl", i), 32'(cap & sh), 0);
        if (rd && we)
            chk(tag("rd_wr_same_addr", i), 32'(ra == wa), 0);
        if (rd) begin
            take(i, 0, "rd", ra, 0);
            last_rd[i] = cyc;
        end
        if (cap) begin
            chk(tag("cap_lat", i), 32'(cyc - last_rd[i]), 32'(P_L[i]));
            take(i, 1, "cap", kr, ch);
        end
        if (sh) begin
            chk(tag("shift_lat", i), 32'(cyc - last_rd[i]), 32'(P_L[i]));
            take(i, 2, "shift", 0, 0);
            last_sh[i] = cyc;
        end
        if (we) begin
            chk(tag("we_after_shift", i), 32'(cyc - last_sh[i]), 1);
            take(i, 3, "wr", wa, 0);
            we_cnt[i]++;
        end
        if (dn) begin
            take(i, 4, "done", 0, 0);
            done_cnt[i]++;
        end
    endtask

    // reference model: cycle count, go acceptance and reset abort
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            for (int j = 0; j < 15; j++) q[j].delete();
            for (int i = 0; i < 3; i++) begin
                run_start[i] = 0;
                run_end[i]   = -10;
            end
        end else begin
            if (go_a && cyc >= run_end[0] + 2) plan(0, cyc - 1);
            if (go_b && cyc >= run_end[1] + 2) plan(1, cyc - 1);
            if (go_c && cyc >= run_end[2] + 2) plan(2, cyc - 1);
        end
    end

    // monitor: every strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (armed) begin
            mon(0, a_bz, a_dn, a_rd, 32'(a_ra), a_cap, 32'(a_kr),
                a_sh, 32'(a_ch), a_we, 32'(a_wa));
            mon(1, b_bz, b_dn, b_rd, 32'(b_ra), b_cap, 32'(b_kr),
                b_sh, 32'(b_ch), b_we, 32'(b_wa));
            mon(2, c_bz, c_dn, c_rd, 32'(c_ra), c_cap, 32'(c_kr),
                c_sh, 32'(c_ch), c_we, 32'(c_wa));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(int i, int target, int budget);
        int t;
        t = 0;
        while (done_cnt[i] < target && t < budget) begin
            step();
            t++;
        end
        chk(tag("done_wait", i), 32'(done_cnt[i] >= target), 1);
    endtask

    task automatic chk_a_zero(string nm);
        chk({nm, "_busy"}, 32'(a_bz), 0);
        chk({nm, "_done"}, 32'(a_dn), 0);
        chk({nm, "_rd_en"}, 32'(a_rd), 0);
        chk({nm, "_rd_addr"}, 32'(a_ra), 0);
        chk({nm, "_ker_cap"}, 32'(a_cap), 0);
        chk({nm, "_row_shift"}, 32'(a_sh), 0);
        chk({nm, "_we"}, 32'(a_we), 0);
        chk({nm, "_wr_addr"}, 32'(a_wa), 0);
        chk({nm, "_ch_idx"}, 32'(a_ch), 0);
    endtask

    initial begin
        int n, t;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        armed    = 1'b0;
        reset    = 1'b1;
        go_a     = 1'b0;
        go_b     = 1'b0;
        go_c     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_start[i] = 0;
            run_end[i]   = -10;
            last_rd[i]   = 0;
            last_sh[i]   = 0;
            we_cnt[i]    = 0;
            done_cnt[i]  = 0;
        end
        repeat (3) step();
        reset = 1'b0;
        armed = 1'b1;
        repeat (2) step();
        chk_a_zero("reset_state");
        chk("reset_state_b_ch", 32'(b_ch), 0);
        chk("reset_state_c_busy", 32'(c_bz), 0);

        // default, multi-channel and long-latency/wrapping runs together
        go_a = 1'b1;
        go_b = 1'b1;
        go_c = 1'b1;
        step();
        go_a = 1'b0;
        go_b = 1'b0;
        go_c = 1'b0;
        wait_done(0, 1, 300);
        wait_done(1, 1, 300);
        wait_done(2, 1, 300);
        repeat (3) step();

        // go pulsed in the middle of RUN is ignored
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        repeat (25) step();
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        wait_done(0, 2, 300);
        repeat (3) step();

        // go held high: back-to-back runs
        go_a = 1'b1;
        wait_done(0, 3, 300);
        repeat (3) step();
        go_a = 1'b0;
        wait_done(0, 4, 300);
        repeat (3) step();

        // reset on the fifth write aborts the run
        n = we_cnt[0];
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        t = 0;
        while (we_cnt[0] < n + 5 && t < 300) begin
            step();
            t++;
        end
        chk("fifth_write_seen", 32'(we_cnt[0] >= n + 5), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_a_zero("abort");
        repeat (60) step();
        chk("abort_no_done", 32'(done_cnt[0]), 4);
        go_a = 1'b1;
        step();
        go_a = 1'b0;
        wait_done(0, 5, 300);
        repeat (4) step();

        for (int j = 0; j < 15; j++)
            chk(tag("leftover", j), 32'(q[j].size()), 0);
        chk("done_total_a", 32'(done_cnt[0]), 5);
        chk("done_total_b", 32'(done_cnt[1]), 1);
        chk("done_total_c", 32'(done_cnt[2]), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
